// File: rtl/hamming_encoder_tx_if.sv
// Stream/serial bundle for hamming_encoder_tx: nibble input handshake plus
// the serial line and the loopback codeword.
interface hamming_encoder_tx_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_frame;
  logic [6:0] code_out;

  // Producer of nibbles and consumer of the serial stream.
  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_frame, code_out
  );

  // The encoder itself.
  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_frame, code_out
  );
endinterface

// File: rtl/hamming_encoder_tx.sv
// Streaming Hamming(7,4) encoder + MSB-first serializer with a small input FIFO.
// Codeword layout: code[4]=d3, code[2]=d2, code[1]=d1, code[0]=d0,
// parity in code[6], code[5], code[3] (decoder position p == code[7-p]).
// Optional macro HAMMING_ERR_INJECT_EN adds the inj_pos port, which flips
// code[7-inj_pos] on each load when nonzero.
module hamming_encoder_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  hamming_encoder_tx_if.slave             bus,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic [2:0]                      inj_pos
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [3:0]    head_data;

  // Serializer state
  state_t        state_q;
  state_t        state_d;
  logic [2:0]    cnt_q;
  logic [2:0]    cnt_d;
  logic [6:0]    shreg_q;
  logic [6:0]    shreg_d;
  logic [6:0]    code_out_q;
  logic          ser_out_q;
  logic          ser_valid_q;
  logic          ser_frame_q;

  logic [6:0]    enc_code;
  logic [6:0]    load_code;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[4] = d[3];
    c[2] = d[2];
    c[1] = d[1];
    c[0] = d[0];
    c[6] = c[4] ^ c[2] ^ c[0];
    c[5] = c[4] ^ c[1] ^ c[0];
    c[3] = c[2] ^ c[1] ^ c[0];
    return c;
  endfunction

  // in_ready comes only from the registered full flag (plus reset), never from pop.
  assign bus.in_ready = !full_q && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign fifo_empty   = (count_q == '0);
  assign head_data    = mem_q[rd_ptr_q];
  assign enc_code     = encode(head_data);

`ifdef HAMMING_ERR_INJECT_EN
  assign load_code = (inj_pos != 3'd0) ? (enc_code ^ (7'd1 << (3'd7 - inj_pos))) : enc_code;
`else
  assign load_code = enc_code;
`endif

  assign count_d = count_q + CW'(push) - CW'(pop);

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // FIFO pointers, occupancy and full flag; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
    end
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state: load from FIFO in IDLE or at the last bit (gapless frames), else shift.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = load_code;
          cnt_d   = 3'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 3'd6) begin
          cnt_d = 3'd0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = load_code;
          end else begin
            shreg_d = {shreg_q[5:0], 1'b0};
            state_d = ST_IDLE;
          end
        end else begin
          shreg_d = {shreg_q[5:0], 1'b0};
          cnt_d   = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered serial outputs; code_out latches the word as its first bit goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_frame_q <= 1'b0;
      code_out_q  <= 7'd0;
    end else begin
      ser_valid_q <= (state_q == ST_SHIFT);
      ser_out_q   <= (state_q == ST_SHIFT) && shreg_q[6];
      ser_frame_q <= (state_q == ST_SHIFT) && (cnt_q == 3'd0);
      if ((state_q == ST_SHIFT) && (cnt_q == 3'd0)) begin
        code_out_q <= shreg_q;
      end
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_frame = ser_frame_q;
  assign bus.code_out  = code_out_q;
  assign busy          = (state_q == ST_SHIFT);
  assign fifo_count    = count_q;

endmodule
